uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

- UART transmit framer that sits directly downstream of the parity generator.
- Accepts a parallel byte, the parity type and the parity generator's `parity_out` through a valid/ready handshake.
- Serializes one frame on `tx_out`, LSB first: start bit, data bits, optional parity bit, stop bit(s).
- Bit timing comes from an externally supplied one-cycle `baud_tick`.

## Interface
- `DATA_W`, default 8: data bits per frame; must match the parity generator width.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `baud_tick`  in  1  one-cycle pulse per bit period.
- `data_in`  in  DATA_W  byte to transmit; sampled on accept.
- `data_valid`  in  1  upstream request.
- `data_ready`  out  1  high only in IDLE; accept = `data_valid & data_ready`.
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 odd computed but not framed; sampled on accept.
- `parity_in`  in  1  parity generator output for the same `data_in`; sampled on accept.
- `tx_out`  out  1  serial line, registered, idle high.
- `busy`  out  1  high from accept until return to IDLE.
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE
  - `tx_out`=1, `data_ready`=1, `busy`=0.
  - On accept: latch `data_in`, `parity_type` and `parity_in` into shadow registers; go to ARM.
- ARM
  - `tx_out`=1.
  - On `baud_tick`: go to START. This aligns the start bit to a full bit period.
- START
  - `tx_out`=0.
  - On `baud_tick`: go to DATA with bit counter = 0.
- DATA
  - `tx_out` = shadow[counter].
  - On `baud_tick`: if counter == DATA_W-1, go to PARITY when latched type is 01 or 10, otherwise go to STOP. Else increment counter.
- PARITY
  - `tx_out` = latched `parity_in`.
  - On `baud_tick`: go to STOP.
- STOP
  - `tx_out`=1.
  - On `baud_tick`: when stop counter == STOP_BITS-1, go to IDLE and pulse `done`; otherwise increment the stop counter.
- Counters: bit counter width is $clog2(DATA_W); stop counter is 1 bit. Both clear on entry to DATA and STOP respectively.
- Parity type 11 frames exactly like 00; the parity bit is not transmitted.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `tx_out`=1, `data_ready`=1, `busy`=0, `done`=0, counters 0, shadow registers 0.
- `tx_out`, `busy` and `done` are registered; each changes in the cycle after the tick or accept that causes it.
- Frame length from the first tick after accept to the return to IDLE: 1 + DATA_W + P + STOP_BITS ticks, where P=1 for types 01/10 and 0 otherwise. This gives 10 or 11 ticks at defaults.
- Accept to first `tx_out` low = cycles until the next `baud_tick` + 1.
- `done` is high for exactly one cycle, coincident with the first IDLE cycle. `data_ready` is 1 in that cycle, so back-to-back frames need no gap cycle beyond ARM.
- `data_valid` with `baud_tick` in the same IDLE cycle: accept, but the tick is not consumed. ARM still waits for the next tick.
- `data_valid` while not in IDLE: ignored; no latch, no side effect.
- Input changes during a frame (`data_in`, `parity_type`, `parity_in`): no effect on the frame in flight.
- `rst` mid-frame: abort. The line returns to 1 the next cycle, with no `done` pulse.
- `baud_tick` held high for consecutive cycles: each high cycle counts as one tick; no error detection.

## Structure
- Package `uart_pkg` holds:
  - state enum `tx_state_t`;
  - parity constants `PAR_NONE`=2'b00, `PAR_ODD`=2'b01, `PAR_EVEN`=2'b10, `PAR_ODD_NOFRAME`=2'b11;
  - `UART_DATA_W`=8.
- One natural sub-module, `uart_baud_gen`: a clock divider with parameter CLKS_PER_BIT, producing `baud_tick`. It is instantiated at the UART top level beside this block, not inside it.
- The parity generator stays a separate instance. Its `parity_out` is wired to `parity_in`, and both blocks share the same `data_in`.

## Test plan
- Odd frame: `data_in`=8'hA5, type 01, `parity_in`=1, tick every 16 cycles.
  - Required `tx_out` per tick: 0,1,0,1,0,0,1,0,1,1,1 (start, LSB-first data, parity, stop).
  - `done` pulses once, 11 ticks after ARM exits.
- Even frame: 8'h00, type 10, `parity_in`=0 → parity bit 0. Type 11 with 8'h00 → 10-bit frame, no parity bit.
- Back-to-back: two frames (8'h55 then 8'hFF, type 00).
  - The second accept happens in the `done` cycle.
  - Line stays high through ARM; no glitch low between frames.
- Busy rejection: pulse `data_valid` with 8'h3C mid-DATA. Required: `data_ready`=0, the in-flight frame is unchanged, and 8'h3C is never transmitted.
- Reset mid-frame: assert `rst` during DATA bit 4. Required next cycle: `tx_out`=1, `busy`=0, `done`=0, `data_ready`=1. A following 8'h81 frame is correct.
- STOP_BITS=2, type 00, 8'hF0: 11 ticks, with two high stop bits before `done`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - tx_state_t      : framer state encoding
//   - PAR_* constants : parity_type encodings shared with the parity generator
//   - UART_DATA_W     : default data width of a frame
//   - parity_framed() : true when the parity bit is actually put on the line
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] PAR_NONE        = 2'b00;
  localparam logic [1:0] PAR_ODD         = 2'b01;
  localparam logic [1:0] PAR_EVEN        = 2'b10;
  localparam logic [1:0] PAR_ODD_NOFRAME = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Type 11 still has parity computed upstream, but the bit is not framed.
  function automatic logic parity_framed(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Free-running clock divider producing a one-cycle baud_tick every
//   CLKS_PER_BIT clock cycles. Instantiated at the UART top level beside
//   uart_tx_frame and feeding its baud_tick input.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   baud_tick out registered one-cycle pulse per bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign baud_tick = tick_reg;

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmit framer. Accepts a data word plus parity type and the
//   parity generator's output through a valid/ready handshake, then sends
//   start bit, DATA_W data bits LSB first, optional parity bit and
//   STOP_BITS stop bits, one bit per baud_tick.
// Ports:
//   clk         in  system clock (rising edge)
//   rst         in  synchronous active-high reset
//   baud_tick   in  one-cycle pulse per bit period
//   data_in     in  word to transmit, sampled on accept
//   data_valid  in  upstream request
//   data_ready  out high only in IDLE
//   parity_type in  00 none, 01 odd, 10 even, 11 odd not framed
//   parity_in   in  parity bit for data_in, sampled on accept
//   tx_out      out registered serial line, idle high
//   busy        out registered, high from accept until back in IDLE
//   done        out registered one-cycle pulse on frame completion
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [1:0]        parity_type,
  input  logic              parity_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic [DATA_W-1:0] data_sh_reg;
  logic [1:0]        ptype_sh_reg;
  logic              par_sh_reg;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              accept;

  assign data_ready = (state_reg == ST_IDLE);
  assign accept     = data_valid & data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      data_sh_reg  <= '0;
      ptype_sh_reg <= PAR_NONE;
      par_sh_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      if (accept) begin
        data_sh_reg  <= data_in;
        ptype_sh_reg <= parity_type;
        par_sh_reg   <= parity_in;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    done_next     = 1'b0;
    tx_next       = 1'b1;

    case (state_reg)
      // A tick coinciding with accept is deliberately ignored so the start
      // bit always begins on a fresh tick and lasts a full bit period.
      ST_IDLE: if (accept) state_next = ST_ARM;
      ST_ARM: if (baud_tick) state_next = ST_START;
      ST_START: begin
        if (baud_tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg == BIT_LAST) begin
            if (parity_framed(ptype_sh_reg)) begin
              state_next = ST_PARITY;
            end else begin
              state_next    = ST_STOP;
              stop_cnt_next = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = data_sh_reg[bit_cnt_next];
      ST_PARITY: tx_next = par_sh_reg;
      default:   tx_next = 1'b1;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign tx_out = tx_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Directed bench for uart_tx_frame: table of frames with hand-computed
//   line sequences, plus hand-written sequences for reset mid-frame.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       man_tick, use_gen, sel2, dv;
  logic       gen_tick, baud_tick;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       parity_in;
  logic       tx1, busy1, done1, ready1;
  logic       tx2, busy2, done2, ready2;
  logic       tx_s, busy_s, done_s, ready_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign baud_tick = use_gen ? gen_tick : man_tick;
  assign tx_s      = sel2 ? tx2    : tx1;
  assign busy_s    = sel2 ? busy2  : busy1;
  assign done_s    = sel2 ? done2  : done1;
  assign ready_s   = sel2 ? ready2 : ready1;

  uart_baud_gen #(.CLKS_PER_BIT(16)) u_gen (
    .clk(clk), .rst(rst), .baud_tick(gen_tick)
  );

  uart_tx_frame #(.DATA_W(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
    .data_valid(dv & ~sel2), .data_ready(ready1), .parity_type(parity_type),
    .parity_in(parity_in), .tx_out(tx1), .busy(busy1), .done(done1)
  );

  uart_tx_frame #(.DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
    .data_valid(dv & sel2), .data_ready(ready2), .parity_type(parity_type),
    .parity_in(parity_in), .tx_out(tx2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  ptype;
    logic        par;
    int          nbits;     // line bits in the frame
    logic [11:0] bits;      // bits[t] = t-th bit on the line, start first
    logic        use_gen;   // ticks from uart_baud_gen instead of manual
    logic        stop2;     // run on the STOP_BITS=2 instance
    logic        tick_acc;  // tick asserted in the accept cycle
    logic        inject;    // pulse data_valid with 8'h3C mid-DATA
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Returns at the falling edge after the tick has been registered.
  task automatic do_tick(input logic cur, input logic inject, input string tag);
    int cnt;
    if (use_gen) begin
      cnt = 0;
      while (!gen_tick && cnt < 40) begin
        check({tag, " line_gap"}, tx_s, cur);
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 40) check({tag, " tick_timeout"}, 1'b0, 1'b1);
      @(negedge clk);
    end else begin
      for (int g = 0; g < GAP; g++) begin
        check({tag, " line_gap"}, tx_s, cur);
        if (inject && g == 0) begin
          dv = 1'b1;
          data_in = 8'h3C;
          check({tag, " ready_busy"}, ready_s, 1'b0);
        end
        @(negedge clk);
        dv = 1'b0;
      end
      man_tick = 1'b1;
      @(negedge clk);
      man_tick = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    string tag;
    logic  cur;
    tag = $sformatf("f%0d", idx);
    use_gen = v.use_gen;
    sel2 = v.stop2;
    data_in = v.data;
    parity_type = v.ptype;
    parity_in = v.par;
    check({tag, " ready_pre"}, ready_s, 1'b1);
    dv = 1'b1;
    man_tick = v.tick_acc;
    @(negedge clk);
    dv = 1'b0;
    man_tick = 1'b0;
    // Scramble inputs: the frame in flight must not see them.
    data_in = ~v.data;
    parity_type = ~v.ptype;
    parity_in = ~v.par;
    check({tag, " busy_acc"}, busy_s, 1'b1);
    check({tag, " ready_acc"}, ready_s, 1'b0);
    check({tag, " done_acc"}, done_s, 1'b0);
    cur = 1'b1;
    for (int t = 0; t <= v.nbits; t++) begin
      do_tick(cur, v.inject && t == 4, tag);
      if (t < v.nbits) begin
        cur = v.bits[t];
        check($sformatf("%s bit%0d", tag, t), tx_s, cur);
        check($sformatf("%s done_mid%0d", tag, t), done_s, 1'b0);
        check($sformatf("%s busy_mid%0d", tag, t), busy_s, 1'b1);
      end else begin
        check({tag, " done_end"}, done_s, 1'b1);
        check({tag, " busy_end"}, busy_s, 1'b0);
        check({tag, " ready_end"}, ready_s, 1'b1);
        check({tag, " line_end"}, tx_s, 1'b1);
      end
    end
    $display("frame %0d data=%h type=%b par=%b bits=%0d stop2=%0b done", idx, v.data,
             v.ptype, v.par, v.nbits, v.stop2);
  endtask

  initial begin
    vec_t v;
    //          data   type      par  n   line bits (stop..start)          gen   s2    tacc  inj
    vecs[0] = '{8'hA5, PAR_ODD,  1'b1, 11, 12'b0_1_1_10100101_0,           1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, PAR_EVEN, 1'b0, 11, 12'b0_1_0_00000000_0,           1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, PAR_ODD_NOFRAME, 1'b1, 10, 12'b00_1_00000000_0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h55, PAR_NONE, 1'b0, 10, 12'b00_1_01010101_0,            1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, PAR_NONE, 1'b0, 10, 12'b00_1_11111111_0,            1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, PAR_EVEN, 1'b0, 11, 12'b0_1_0_11000011_0,           1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h96, PAR_ODD,  1'b1, 11, 12'b0_1_1_10010110_0,           1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; man_tick = 1'b0; use_gen = 1'b0; sel2 = 1'b0; dv = 1'b0;
    data_in = 8'h00; parity_type = PAR_NONE; parity_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst tx", tx1, 1'b1);
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst ready", ready1, 1'b1);
    check("rst tx2", tx2, 1'b1);
    check("rst ready2", ready2, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive table entries are back-to-back: each accept lands in
    // the previous frame's done cycle.
    for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

    // Reset during DATA bit 4 of an all-zero frame.
    use_gen = 1'b0; sel2 = 1'b0;
    data_in = 8'h00; parity_type = PAR_NONE; parity_in = 1'b0;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    do_tick(1'b1, 1'b0, "rstseq");
    for (int t = 0; t < 5; t++) do_tick(1'b0, 1'b0, "rstseq");
    check("rstseq bit4_low", tx1, 1'b0);
    check("rstseq busy_pre", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstseq tx", tx1, 1'b1);
    check("rstseq busy", busy1, 1'b0);
    check("rstseq done", done1, 1'b0);
    check("rstseq ready", ready1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstseq done_after", done1, 1'b0);
      check("rstseq tx_after", tx1, 1'b1);
    end
    $display("frame reset-abort data=00 aborted at bit4");

    v = '{8'h81, PAR_NONE, 1'b0, 10, 12'b00_1_10000001_0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(v, 7);
    v = '{8'hF0, PAR_NONE, 1'b0, 11, 12'b0_1_1_11110000_0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_frame(v, 8);

    @(negedge clk);
    check("final done2_clear", done2, 1'b0);
    check("final busy1", busy1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
